// File: rtl/aes_pkg.sv
// AES-128 shared constants and GF(2^8) helpers (polynomial 0x11B).
// Holds the S-boxes, round constants and the core FSM state type.
package aes_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_KEYEXP, ST_ADDKEY, ST_ROUND, ST_DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round; DECRYPT selects forward or inverse transform order.
// Zero latency, no flow control; final_round drops (Inv)MixColumns.
module aes_round import aes_pkg::*; #(
  parameter int DECRYPT = 0
) (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  // Circulant column mix: output byte i sums gmul(a_j, m[(j - i) mod 4]).
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic [31:0] m);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        o[31-8*i -: 8] = o[31-8*i -: 8] ^ gmul(col[31-8*j -: 8], m[31-8*((j-i+4)%4) -: 8]);
    return o;
  endfunction

  if (DECRYPT == 0) begin : g_enc
    logic [127:0] w_sub, w_shift, w_mix;
    always_comb begin
      w_sub   = '0;
      w_shift = '0;
      w_mix   = '0;
      for (int b = 0; b < 16; b++) w_sub[127-8*b -: 8] = SBOX[state_in[127-8*b -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          w_shift[127-8*(4*c+r) -: 8] = w_sub[127-8*(4*((c+r)%4)+r) -: 8];
      for (int c = 0; c < 4; c++) w_mix[127-32*c -: 32] = mix_col(w_shift[127-32*c -: 32], 32'h02030101);
    end
    assign state_out = (final_round ? w_shift : w_mix) ^ round_key;
  end else begin : g_dec
    logic [127:0] w_isr, w_isb, w_ark, w_imix;
    always_comb begin
      w_isr  = '0;
      w_isb  = '0;
      w_imix = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          w_isr[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r+4)%4)+r) -: 8];
      for (int b = 0; b < 16; b++) w_isb[127-8*b -: 8] = INV_SBOX[w_isr[127-8*b -: 8]];
      w_ark = w_isb ^ round_key;
      for (int c = 0; c < 4; c++) w_imix[127-32*c -: 32] = mix_col(w_ark[127-32*c -: 32], 32'h0e0b0d09);
    end
    assign state_out = final_round ? w_ark : w_imix;
  end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128 core: 10 key-expansion cycles, 1 AddRoundKey, 10 rounds -> done 21 cycles after start.
// No backpressure: start is sampled only in IDLE, DONE holds until reset; AES_OUTPUT_MASK_EN zeroes output until done.
module aes_cipher import aes_pkg::*; #(
  parameter int DECRYPT = 0
) (
  input  logic         clock,
  input  logic         resetModule,
  input  logic [127:0] inputData,
  input  logic [127:0] key,
  input  logic         inputsLoadedFlag,
  output logic [127:0] outputData,
  output logic         dataDoneFlag
);

  state_t       r_state, w_next;
  logic [3:0]   r_round;
  logic [127:0] r_data, r_out;
  logic         r_done;
  logic [127:0] r_rk [11];

  logic [3:0]   w_kidx, w_rk_idx;
  logic [127:0] w_prev, w_rk_sel, w_round_out;
  logic [31:0]  w_temp, w_k0, w_k1, w_k2, w_k3;
  logic         w_final;

  always_ff @(posedge clock) begin
    if (resetModule) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (inputsLoadedFlag) w_next = ST_KEYEXP;
      ST_KEYEXP: if (r_round == 4'd10) w_next = ST_ADDKEY;
      ST_ADDKEY: w_next = ST_ROUND;
      ST_ROUND:  if (r_round == 4'd10) w_next = ST_DONE;
      ST_DONE:   w_next = ST_DONE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Clamp keeps the expansion indices in range while the counter idles at 0.
  assign w_kidx = (r_round == 4'd0 || r_round > 4'd10) ? 4'd1 : r_round;
  assign w_prev = r_rk[w_kidx - 4'd1];
  assign w_temp = sub_word(rot_word(w_prev[31:0])) ^ {RCON[w_kidx], 24'h0};
  assign w_k0   = w_prev[127:96] ^ w_temp;
  assign w_k1   = w_prev[95:64]  ^ w_k0;
  assign w_k2   = w_prev[63:32]  ^ w_k1;
  assign w_k3   = w_prev[31:0]   ^ w_k2;

  assign w_rk_idx = (DECRYPT != 0) ? 4'd10 - r_round : r_round;
  assign w_rk_sel = r_rk[w_rk_idx];
  assign w_final  = (r_round == 4'd10);

  aes_round #(.DECRYPT(DECRYPT)) u_round (
    .state_in    (r_data),
    .round_key   (w_rk_sel),
    .final_round (w_final),
    .state_out   (w_round_out)
  );

  always_ff @(posedge clock) begin
    if (r_state == ST_IDLE && inputsLoadedFlag) r_rk[0] <= key;
    else if (r_state == ST_KEYEXP)              r_rk[r_round] <= {w_k0, w_k1, w_k2, w_k3};
  end

  always_ff @(posedge clock) begin
    if (resetModule) begin
      r_round <= 4'd0;
      r_data  <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (inputsLoadedFlag) begin
          r_data  <= inputData;
          r_round <= 4'd1;
        end
        ST_KEYEXP: if (r_round != 4'd10) r_round <= r_round + 4'd1;
        ST_ADDKEY: begin
          r_data  <= r_data ^ ((DECRYPT != 0) ? r_rk[10] : r_rk[0]);
          r_round <= 4'd1;
        end
        ST_ROUND: begin
          r_data <= w_round_out;
          if (r_round == 4'd10) begin
            r_out  <= w_round_out;
            r_done <= 1'b1;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AES_OUTPUT_MASK_EN
  assign outputData = r_done ? r_out : '0;
`else
  assign outputData = r_out;
`endif
  assign dataDoneFlag = r_done;

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for encrypt and decrypt instances of aes_cipher driven side by side.
module tb_aes_cipher;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clock;
  logic         resetModule;
  logic [127:0] key;
  logic [127:0] data_enc, data_dec;
  logic         start;
  logic [127:0] out_enc, out_dec;
  logic         done_enc, done_dec;

  int checks;
  int failures;

  aes_cipher #(.DECRYPT(0)) u_enc (
    .clock            (clock),
    .resetModule      (resetModule),
    .inputData        (data_enc),
    .key              (key),
    .inputsLoadedFlag (start),
    .outputData       (out_enc),
    .dataDoneFlag     (done_enc)
  );

  aes_cipher #(.DECRYPT(1)) u_dec (
    .clock            (clock),
    .resetModule      (resetModule),
    .inputData        (data_dec),
    .key              (key),
    .inputsLoadedFlag (start),
    .outputData       (out_dec),
    .dataDoneFlag     (done_dec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_enc_done"}, {127'b0, done_enc}, 128'd0);
    check({tag, "_dec_done"}, {127'b0, done_dec}, 128'd0);
    check({tag, "_enc_out"}, out_enc, 128'd0);
    check({tag, "_dec_out"}, out_dec, 128'd0);
  endtask

  task automatic pulse_reset();
    resetModule = 1'b1;
    start       = 1'b0;
    tick();
    resetModule = 1'b0;
  endtask

  // Start at E0, optionally corrupt inputs right after E0, optionally hold start for
  // 'hold' cycles; outputs must stay idle through E20 and show the result from E21 on.
  task automatic run_block(input string tag, input logic [127:0] k, input logic [127:0] de,
                           input logic [127:0] dd, input logic [127:0] ee, input logic [127:0] ed,
                           input bit change, input int hold);
    int last;
    key      = k;
    data_enc = de;
    data_dec = dd;
    start    = 1'b1;
    tick();
    if (hold == 0) start = 1'b0;
    if (change) begin
      key      = '1;
      data_enc = '1;
      data_dec = '1;
    end
    last = (hold > 21) ? hold : 21;
    for (int n = 1; n <= last; n++) begin
      tick();
      if (n == hold) start = 1'b0;
      if (n < 21) begin
        check_idle($sformatf("%s_e%0d", tag, n));
      end else begin
        check($sformatf("%s_e%0d_enc_done", tag, n), {127'b0, done_enc}, 128'd1);
        check($sformatf("%s_e%0d_dec_done", tag, n), {127'b0, done_dec}, 128'd1);
        check($sformatf("%s_e%0d_enc_out", tag, n), out_enc, ee);
        check($sformatf("%s_e%0d_dec_out", tag, n), out_dec, ed);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    resetModule = 1'b1;
    start       = 1'b0;
    key         = '0;
    data_enc    = '0;
    data_dec    = '0;
    tick();
    tick();
    check_idle("reset");
    resetModule = 1'b0;
    tick();
    check_idle("idle_no_start");

    run_block("c1", K1, P1, C1, C1, P1, 1'b0, 0);

    pulse_reset();
    check_idle("c1_cleared");
    run_block("appb", K2, P2, C2, C2, P2, 1'b0, 0);

    pulse_reset();
    run_block("chg_e1", K1, P1, C1, C1, P1, 1'b1, 0);

    pulse_reset();
    run_block("held", K1, P1, C1, C1, P1, 1'b0, 40);
    pulse_reset();
    check_idle("held_reset");

    key      = K2;
    data_enc = P2;
    data_dec = C2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      tick();
      check_idle($sformatf("abort_e%0d", n));
    end
    // Reset and start arrive together at E8: reset must win.
    resetModule = 1'b1;
    start       = 1'b1;
    key         = K1;
    data_enc    = P1;
    data_dec    = C1;
    tick();
    check_idle("abort_e8_reset");
    resetModule = 1'b0;
    run_block("restart", K1, P1, C1, C1, P1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
